// File: rtl/clq_walk_ctrl.sv
// -----------------------------------------------------------------------------
// clq_walk_ctrl
//
// Walks the linked clause list of one literal in the clause queue. The head
// pointer is looked up once, then each node is read, registered and offered to
// the BCP engine, and its next-pointer is followed until the end-of-list marker
// or until DEPTH nodes have been fetched (a guard against cyclic or corrupt
// lists).
//
// Ports
//   clk, rst_n            clock; synchronous active-HIGH reset (legacy name)
//   req_lit_i/_valid_i    literal request from the UC arbiter
//   req_ready_o           request accepted when idle and not flushing
//   clq_lit_o/_valid_o    head-pointer lookup to the clause queue
//   clq_init_ptr_i/_valid head pointer (combinational), valid=0 -> empty list
//   clq_idx_o             node index read from the clause queue
//   clq_node_i/next_i/    node payload and link fields at clq_idx_o
//     next_valid_i        (combinational)
//   bcp_node_o/_valid_o/  registered node stream to the BCP engine
//     _last_o, ready_i
//   flush_i               abort the current walk, highest priority
//   busy_o                controller not idle
//   done_o / err_o        one-cycle pulses: normal end / length guard tripped
//   walk_cnt_o            nodes fetched in the current or most recent walk
// -----------------------------------------------------------------------------
module clq_walk_ctrl #(
  parameter int DEPTH  = 16,
  parameter int LIT_W  = 8,
  parameter int NODE_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LIT_W-1:0]  req_lit_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  output logic [LIT_W-1:0]  clq_lit_o,
  output logic              clq_lit_valid_o,
  input  logic [PTR_W-1:0]  clq_init_ptr_i,
  input  logic              clq_init_ptr_valid_i,
  output logic [PTR_W-1:0]  clq_idx_o,
  input  logic [NODE_W-1:0] clq_node_i,
  input  logic [PTR_W-1:0]  clq_next_i,
  input  logic              clq_next_valid_i,
  output logic [NODE_W-1:0] bcp_node_o,
  output logic              bcp_valid_o,
  output logic              bcp_last_o,
  input  logic              bcp_ready_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [PTR_W:0]    walk_cnt_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_FETCH  = 2'd2;
  localparam logic [1:0] S_ISSUE  = 2'd3;

  localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);

  logic [1:0]        r_state;
  logic [LIT_W-1:0]  r_lit;
  logic [PTR_W-1:0]  r_ptr;
  logic [NODE_W-1:0] r_node;
  logic [PTR_W-1:0]  r_next;
  logic              r_next_valid;
  logic [PTR_W:0]    r_cnt;
  logic              r_done;
  logic              r_err;

  // NOTE: every sequential register below uses non-blocking assignment so that
  // all state updates within a cycle see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state      <= S_IDLE;
      r_lit        <= '0;
      r_ptr        <= '0;
      r_node       <= '0;
      r_next       <= '0;
      r_next_valid <= 1'b0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Pulses default low; they fire only on the transition into IDLE.
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (flush_i) begin
        // Abort silently. A node handed over in this cycle is already counted,
        // since the count advances in FETCH, not on acceptance.
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (req_valid_i) begin
              r_lit   <= req_lit_i;
              r_cnt   <= '0;
              r_state <= S_LOOKUP;
            end
          end

          S_LOOKUP: begin
            if (clq_init_ptr_valid_i) begin
              r_ptr   <= clq_init_ptr_i;
              r_state <= S_FETCH;
            end else begin
              // Empty list: nothing to stream, the walk is trivially complete.
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end

          S_FETCH: begin
            r_node       <= clq_node_i;
            r_next       <= clq_next_i;
            r_next_valid <= clq_next_valid_i;
            r_cnt        <= r_cnt + CNT_ONE;
            r_state      <= S_ISSUE;
          end

          S_ISSUE: begin
            if (bcp_ready_i) begin
              if (!r_next_valid) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end else if (r_cnt == CNT_MAX) begin
                // More nodes than the queue can hold means the list loops.
                r_state <= S_IDLE;
                r_err   <= 1'b1;
              end else begin
                r_ptr   <= r_next;
                r_state <= S_FETCH;
              end
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Outputs are decoded directly from registered state; only req_ready_o looks
  // at an input (flush_i) so that a flush also blocks a new request.
  assign req_ready_o     = (r_state == S_IDLE) && !flush_i;
  assign busy_o          = (r_state != S_IDLE);
  assign clq_lit_o       = r_lit;
  assign clq_lit_valid_o = (r_state == S_LOOKUP);
  assign clq_idx_o       = r_ptr;
  assign bcp_node_o      = r_node;
  assign bcp_valid_o     = (r_state == S_ISSUE);
  assign bcp_last_o      = (r_state == S_ISSUE) && !r_next_valid;
  assign done_o          = r_done;
  assign err_o           = r_err;
  assign walk_cnt_o      = r_cnt;

endmodule

// File: tb/tb_clq_walk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clq_walk_ctrl
//
// Bench for clq_walk_ctrl. A small clause-queue memory (head table plus node
// array) answers the controller's lookups combinationally. The expected node
// stream of each walk is obtained by following the list in that memory from
// the head, stopping at end-of-list or after DEPTH nodes. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_clq_walk_ctrl;

  localparam int DEPTH  = 16;
  localparam int LIT_W  = 8;
  localparam int NODE_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int BUDGET = 200;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [LIT_W-1:0]  req_lit_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [LIT_W-1:0]  clq_lit_o;
  logic              clq_lit_valid_o;
  logic [PTR_W-1:0]  clq_init_ptr_i;
  logic              clq_init_ptr_valid_i;
  logic [PTR_W-1:0]  clq_idx_o;
  logic [NODE_W-1:0] clq_node_i;
  logic [PTR_W-1:0]  clq_next_i;
  logic              clq_next_valid_i;
  logic [NODE_W-1:0] bcp_node_o;
  logic              bcp_valid_o;
  logic              bcp_last_o;
  logic              bcp_ready_i;
  logic              flush_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [PTR_W:0]    walk_cnt_o;

  // Clause-queue model
  logic [NODE_W-1:0] mem_node [DEPTH];
  logic [PTR_W-1:0]  mem_next [DEPTH];
  logic              mem_nv   [DEPTH];
  logic [PTR_W-1:0]  head_ptr [256];
  logic              head_vld [256];

  assign clq_init_ptr_i       = head_ptr[clq_lit_o];
  assign clq_init_ptr_valid_i = head_vld[clq_lit_o];
  assign clq_node_i           = mem_node[clq_idx_o];
  assign clq_next_i           = mem_next[clq_idx_o];
  assign clq_next_valid_i     = mem_nv[clq_idx_o];

  clq_walk_ctrl #(.DEPTH(DEPTH), .LIT_W(LIT_W), .NODE_W(NODE_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_lit_i            (req_lit_i),
    .req_valid_i          (req_valid_i),
    .req_ready_o          (req_ready_o),
    .clq_lit_o            (clq_lit_o),
    .clq_lit_valid_o      (clq_lit_valid_o),
    .clq_init_ptr_i       (clq_init_ptr_i),
    .clq_init_ptr_valid_i (clq_init_ptr_valid_i),
    .clq_idx_o            (clq_idx_o),
    .clq_node_i           (clq_node_i),
    .clq_next_i           (clq_next_i),
    .clq_next_valid_i     (clq_next_valid_i),
    .bcp_node_o           (bcp_node_o),
    .bcp_valid_o          (bcp_valid_o),
    .bcp_last_o           (bcp_last_o),
    .bcp_ready_i          (bcp_ready_i),
    .flush_i              (flush_i),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .err_o                (err_o),
    .walk_cnt_o           (walk_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [NODE_W-1:0] got_node [$];
  logic              got_last [$];
  int                got_cyc  [$];

  // ---------------------------------------------------------------------------
  // Memory programming helpers
  // ---------------------------------------------------------------------------
  task automatic init_mem();
    for (int i = 0; i < DEPTH; i++) begin
      mem_node[i] = ($urandom() & 32'hFFFF_FFF0) | 32'(i);
      mem_next[i] = PTR_W'($urandom_range(0, DEPTH - 1));
      mem_nv[i]   = 1'b0;
    end
    for (int i = 0; i < 256; i++) begin
      head_ptr[i] = '0;
      head_vld[i] = 1'b0;
    end
  endtask

  // 3 -> 7 -> 2
  task automatic set_list3(input logic [LIT_W-1:0] lit);
    head_ptr[lit] = 4'd3;
    head_vld[lit] = 1'b1;
    mem_next[3] = 4'd7; mem_nv[3] = 1'b1;
    mem_next[7] = 4'd2; mem_nv[7] = 1'b1;
    mem_nv[2] = 1'b0;
  endtask

  task automatic make_rand_list(input logic [LIT_W-1:0] lit, input int n);
    int perm [DEPTH];
    int j, tmp;
    for (int i = 0; i < DEPTH; i++) perm[i] = i;
    for (int i = DEPTH - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int i = 0; i < DEPTH; i++)
      mem_node[i] = ($urandom() & 32'hFFFF_FFF0) | 32'(i);
    head_vld[lit] = (n > 0);
    head_ptr[lit] = PTR_W'(perm[0]);
    for (int i = 0; i < n; i++) begin
      mem_next[perm[i]] = PTR_W'(perm[(i + 1) % DEPTH]);
      mem_nv[perm[i]]   = (i < n - 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // One walk. Called in the falling-edge phase; returns in the falling-edge
  // phase of the first idle cycle after the walk (done/err cycle), so a new
  // walk can be requested in that very cycle.
  //   pct        : percent of cycles bcp_ready_i is high
  //   stall_node : node index held off for stall_len cycles (-1 = none)
  //   flush_node : flush while this node index is offered (-1 = none)
  //   chk_timing : check cycle positions (only meaningful with pct = 100)
  // ---------------------------------------------------------------------------
  task automatic run_walk(input logic [LIT_W-1:0] lit, input int pct,
                          input int stall_node, input int stall_len,
                          input int flush_node, input bit chk_timing,
                          input string name);
    logic [NODE_W-1:0] exp_q [$];
    bit                exp_err, exp_done, fin, flushed, held_v;
    logic [NODE_W-1:0] held;
    int                p, exp_cnt, n_done, n_err, dcyc, stall_left, nexp;
    bit                exp_last;

    // Reference: follow the list from the head.
    exp_err = 1'b0;
    if (head_vld[lit]) begin
      p = head_ptr[lit];
      for (int k = 0; k <= DEPTH; k++) begin
        exp_q.push_back(mem_node[p]);
        if (!mem_nv[p]) break;
        if (exp_q.size() == DEPTH) begin exp_err = 1'b1; break; end
        p = mem_next[p];
      end
    end
    exp_cnt  = exp_q.size();
    exp_done = !exp_err;
    if (flush_node >= 0) begin
      while (exp_q.size() > flush_node) void'(exp_q.pop_back());
      exp_cnt  = flush_node + 1;
      exp_err  = 1'b0;
      exp_done = 1'b0;
    end

    got_node.delete(); got_last.delete(); got_cyc.delete();
    fin = 0; flushed = 0; held_v = 0; held = '0;
    n_done = 0; n_err = 0; dcyc = -1; stall_left = stall_len;

    for (int t = 0; t < BUDGET && !fin; t++) begin
      // Registered outputs first (independent of this cycle's inputs).
      if (t > 0 && done_o) begin n_done++; dcyc = t; end
      if (t > 0 && err_o) n_err++;
      if (held_v && bcp_valid_o) begin
        n_cmp++;
        if (bcp_node_o !== held) begin
          n_fail++;
          $display("FAIL %s stall_hold t=%0d: got %h exp %h", name, t, bcp_node_o, held);
        end
      end
      if (flushed) begin
        n_cmp++;
        if (busy_o !== 1'b0 || bcp_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s post_flush: busy=%b valid=%b exp 0/0", name, busy_o, bcp_valid_o);
        end
        fin = 1;
      end else if (t > 0 && !busy_o) begin
        fin = 1;
      end

      if (fin) begin
        req_valid_i = 1'b0; flush_i = 1'b0; bcp_ready_i = 1'b0;
      end else begin
        req_valid_i = (t == 0);
        req_lit_i   = lit;
        flush_i     = 1'b0;
        if (flush_node >= 0 && bcp_valid_o && got_node.size() == flush_node) begin
          flush_i     = 1'b1;
          bcp_ready_i = 1'b0;
          flushed     = 1;
        end else if (stall_node >= 0 && bcp_valid_o && got_node.size() == stall_node && stall_left > 0) begin
          bcp_ready_i = 1'b0;
          stall_left--;
        end else begin
          bcp_ready_i = ($urandom_range(0, 99) < pct);
        end
        #1;
        if (t == 0) begin
          n_cmp++;
          if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s req_ready: got %b exp 1", name, req_ready_o);
          end
        end
        if (bcp_valid_o && bcp_ready_i) begin
          got_node.push_back(bcp_node_o);
          got_last.push_back(bcp_last_o);
          got_cyc.push_back(t);
        end
        held_v = bcp_valid_o && !bcp_ready_i;
        held   = bcp_node_o;
        @(negedge clk);
      end
    end

    n_cmp++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s timeout: walk not finished in %0d cycles", name, BUDGET);
    end

    nexp = exp_q.size();
    n_cmp++;
    if (got_node.size() !== nexp) begin
      n_fail++;
      $display("FAIL %s node_count: got %0d exp %0d", name, got_node.size(), nexp);
    end
    for (int i = 0; i < nexp && i < got_node.size(); i++) begin
      exp_last = exp_done && (i == nexp - 1);
      n_cmp++;
      if (got_node[i] !== exp_q[i] || got_last[i] !== exp_last) begin
        n_fail++;
        $display("FAIL %s node[%0d]: got %h last %b exp %h last %b", name, i, got_node[i], got_last[i], exp_q[i], exp_last);
      end
      if (chk_timing) begin
        n_cmp++;
        if (got_cyc[i] != 3 + 2 * i) begin
          n_fail++;
          $display("FAIL %s node_cycle[%0d]: got %0d exp %0d", name, i, got_cyc[i], 3 + 2 * i);
        end
      end
    end
    n_cmp++;
    if (n_done != int'(exp_done) || n_err != int'(exp_err)) begin
      n_fail++;
      $display("FAIL %s pulses: done=%0d err=%0d exp done=%0d err=%0d", name, n_done, n_err, exp_done, exp_err);
    end
    if (chk_timing && exp_done) begin
      n_cmp++;
      if (dcyc != 2 * nexp + 2) begin
        n_fail++;
        $display("FAIL %s done_cycle: got %0d exp %0d", name, dcyc, 2 * nexp + 2);
      end
    end
    n_cmp++;
    if (walk_cnt_o !== (PTR_W + 1)'(exp_cnt)) begin
      n_fail++;
      $display("FAIL %s walk_cnt: got %0d exp %0d", name, walk_cnt_o, exp_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || bcp_valid_o !== 1'b0 || bcp_last_o !== 1'b0 ||
        clq_lit_valid_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdy=%b busy=%b v=%b last=%b lv=%b done=%b err=%b exp 1000000",
               req_ready_o, busy_o, bcp_valid_o, bcp_last_o, clq_lit_valid_o, done_o, err_o);
    end
    n_cmp++;
    if (bcp_node_o !== '0 || clq_idx_o !== '0 || clq_lit_o !== '0 || walk_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: node=%h idx=%h lit=%h cnt=%h exp all 0", bcp_node_o, clq_idx_o, clq_lit_o, walk_cnt_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (bcp_valid_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet[%0d]: v=%b done=%b err=%b busy=%b exp 0", i, bcp_valid_o, done_o, err_o, busy_o);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_walk3();
    set_list3(8'h05);
    run_walk(8'h05, 100, -1, 0, -1, 1'b1, "walk3");
  endtask

  task automatic test_empty();
    head_vld[8'h85] = 1'b0;
    run_walk(8'h85, 100, -1, 0, -1, 1'b1, "empty");
  endtask

  task automatic test_backpressure();
    set_list3(8'h05);
    run_walk(8'h05, 100, 1, 4, -1, 1'b0, "stall");
  endtask

  task automatic test_self_loop();
    head_ptr[8'h11] = 4'd4;
    head_vld[8'h11] = 1'b1;
    mem_next[4] = 4'd4;
    mem_nv[4]   = 1'b1;
    run_walk(8'h11, 100, -1, 0, -1, 1'b0, "loop");
  endtask

  task automatic test_flush();
    set_list3(8'h05);
    run_walk(8'h05, 100, -1, 0, 1, 1'b0, "flush");
    run_walk(8'h05, 100, -1, 0, -1, 1'b1, "after_flush");
  endtask

  task automatic test_flush_idle();
    req_valid_i = 1'b1;
    req_lit_i   = 8'h05;
    flush_i     = 1'b1;
    #1;
    n_cmp++;
    if (req_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_ready: got %b exp 0", req_ready_o);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_busy: got %b exp 0", busy_o);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    make_rand_list(8'h22, 5);
    run_walk(8'h22, 100, -1, 0, -1, 1'b1, "b2b_a");
    run_walk(8'h22, 60, -1, 0, -1, 1'b0, "b2b_b");
  endtask

  task automatic test_random();
    logic [LIT_W-1:0] lit;
    for (int it = 0; it < 25; it++) begin
      lit = LIT_W'($urandom());
      make_rand_list(lit, $urandom_range(0, DEPTH));
      if ($urandom_range(0, 3) == 0)
        run_walk(lit, 100, -1, 0, -1, 1'b1, "rand_full");
      else
        run_walk(lit, $urandom_range(25, 95), -1, 0, -1, 1'b0, "rand");
    end
  endtask

  task automatic test_reset_midwalk();
    bit seen;
    set_list3(8'h05);
    req_lit_i   = 8'h05;
    req_valid_i = 1'b1;
    bcp_ready_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bcp_valid_o) seen = 1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midwalk_reach_issue: got valid=0 exp 1 within 10 cycles");
    end
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy_o !== 1'b0 || bcp_valid_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 ||
        walk_cnt_o !== '0 || clq_idx_o !== '0 || clq_lit_o !== '0 || bcp_node_o !== '0) begin
      n_fail++;
      $display("FAIL midwalk_reset: busy=%b v=%b done=%b err=%b cnt=%0d idx=%0d lit=%h node=%h exp all 0",
               busy_o, bcp_valid_o, done_o, err_o, walk_cnt_o, clq_idx_o, clq_lit_o, bcp_node_o);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (done_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midwalk_after: done=%b err=%b busy=%b exp 0", done_o, err_o, busy_o);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b1;
    req_lit_i   = '0;
    req_valid_i = 1'b0;
    bcp_ready_i = 1'b0;
    flush_i     = 1'b0;
    init_mem();
    test_reset();
    test_walk3();
    test_empty();
    test_backpressure();
    test_self_loop();
    test_flush();
    test_flush_idle();
    test_back_to_back();
    test_random();
    test_reset_midwalk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clq_walk_ctrl.md
# clq_walk_ctrl

Sequencer that turns a unit-clause literal request into a walk of that literal's linked clause list in the clause queue. It looks up the literal's dummy head pointer, follows node next-pointers one entry at a time, and streams each clause node to a BCP engine over a valid/ready handshake. It sits between the UC arbiter output and the clause queue/BCP engine pair, owning the queue's lookup and index ports.

## Interface
- DEPTH, 16, clause queue entries; PTR_W = $clog2(DEPTH)
- LIT_W, 8, literal width (sign bit is MSB)
- NODE_W, 32, clause node payload width
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-high (despite the name)
- req_lit_i  in  LIT_W  literal to propagate
- req_valid_i  in  1  request valid
- req_ready_o  out  1  controller can accept a request
- clq_lit_o  out  LIT_W  head-pointer lookup literal to clause queue
- clq_lit_valid_o  out  1  lookup valid
- clq_init_ptr_i  in  PTR_W  head pointer returned (combinational, same cycle)
- clq_init_ptr_valid_i  in  1  head pointer exists; 0 = empty list
- clq_idx_o  out  PTR_W  node index read from clause queue
- clq_node_i  in  NODE_W  node payload at clq_idx_o (combinational)
- clq_next_i  in  PTR_W  next-pointer field of that node
- clq_next_valid_i  in  1  1 = another node follows; 0 = end of list
- bcp_node_o  out  NODE_W  node to BCP engine (registered)
- bcp_valid_o  out  1  node valid
- bcp_last_o  out  1  node is last of the walk
- bcp_ready_i  in  1  BCP engine accepts node
- flush_i  in  1  abort current walk (conflict/backtrack)
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse: walk completed normally
- err_o  out  1  one-cycle pulse: walk exceeded DEPTH nodes
- walk_cnt_o  out  PTR_W+1  nodes fetched in current/last walk

## Operation
- States: IDLE, LOOKUP, FETCH, ISSUE.
- IDLE: req_ready_o = !flush_i. On req_valid_i & req_ready_o: latch literal, clear walk count, -> LOOKUP.
- LOOKUP: clq_lit_o = latched literal, clq_lit_valid_o = 1. If clq_init_ptr_valid_i: ptr <= clq_init_ptr_i, -> FETCH. Else (empty list): -> IDLE, done_o pulse next cycle.
- FETCH: clq_idx_o = ptr. Register clq_node_i into bcp_node_o, latch clq_next_i and clq_next_valid_i, walk count += 1, -> ISSUE.
- ISSUE: bcp_valid_o = 1, bcp_last_o = !latched next_valid; bcp_node_o stable until accepted. On bcp_ready_i:
  - last -> IDLE, done_o pulse.
  - else if walk count == DEPTH -> IDLE, err_o pulse (cyclic/corrupt list guard).
  - else ptr <= latched next -> FETCH.
- clq_idx_o outside FETCH holds ptr; clq_lit_o outside LOOKUP holds latched literal.
- flush_i: highest priority in every state; next state IDLE, no done_o/err_o. A node accepted by BCP in the flush cycle counts as delivered; no further nodes issued.
- walk_cnt_o holds its value after the walk until the next accept.

## Timing
- Reset values: state IDLE, req_ready_o 1, busy_o 0, bcp_valid_o 0, bcp_last_o 0, bcp_node_o 0, clq_lit_valid_o 0, clq_idx_o 0, clq_lit_o 0, done_o 0, err_o 0, walk_cnt_o 0. Reset mid-walk abandons it with no pulse.
- Accept in cycle 0 -> LOOKUP cycle 1 -> FETCH cycle 2 -> first bcp_valid_o cycle 3.
- Throughput: one node per 2 cycles with bcp_ready_i held high; backpressure stalls in ISSUE indefinitely.
- done_o/err_o asserted in the first IDLE cycle; a new request may be accepted in that same cycle.
- Empty list: accept cycle 0, done_o cycle 2, bcp_valid_o never asserted.
- Flush in cycle n: busy_o = 0 and bcp_valid_o = 0 in cycle n+1.

## Test plan
- Reset then idle: all outputs at reset values, req_ready_o = 1 -> no spurious valid/done.
- Literal 0x05, head ptr 3, list 3->7->2 (next_valid 1,1,0), bcp_ready_i = 1 -> nodes at idx 3,7,2 on cycles 3,5,7, bcp_last_o only on idx 2, done_o cycle 8, walk_cnt_o = 3.
- Literal 0x85 with clq_init_ptr_valid_i = 0 -> done_o cycle 2, no bcp_valid_o, walk_cnt_o = 0.
- Same 3-node list, bcp_ready_i low 4 cycles on second node -> bcp_node_o stable throughout, order and last flag preserved.
- Self-loop list (ptr 4 -> 4, next_valid always 1), DEPTH = 16 -> exactly 16 nodes issued, err_o pulse, no done_o.
- flush_i asserted while in ISSUE on second node -> bcp_valid_o low next cycle, no done_o/err_o, immediately following request accepted and walked correctly.
